bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
//   Converts an unsigned binary value into packed BCD digits {..., hundreds, tens, units}.
//   Feeds the 3-digit BCD-to-7-segment display path so register/ALU results appear on HEX LEDs.
//   Uses a start/busy/done handshake. The result is held stable between conversions.
// PARAMETERS
//   BIN_W   8  width of the unsigned binary input (>=1)
//   DIGITS  3  number of BCD output digits (>=1); the output is 4*DIGITS bits
// PORTS
//   clk       input   1           system clock, rising edge
//   rst       input   1           asynchronous reset, active-high
//   start     input   1           request a conversion; sampled only in IDLE
//   bin       input   BIN_W       binary value; captured on the cycle start is accepted
//   busy      output  1           high whenever state != IDLE
//   done      output  1           one-cycle pulse when bcd/overflow are updated
//   bcd       output  4*DIGITS    packed BCD result; digit k is bcd[4k+3:4k], units at [3:0]
//   overflow  output  1           high if the captured bin > 10^DIGITS-1; valid from done onward
// BEHAVIOUR
//   Reset (async, any time, including mid-conversion):
//     - State goes to IDLE. busy=0, done=0, bcd=0, overflow=0.
//     - Shift counter and scratch registers are cleared.
//     - An in-flight conversion is abandoned with no done pulse.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE:
//       - If start=1: capture bin into the shift register, clear the BCD scratch, set count=BIN_W.
//       - Also capture ovf_next = (bin > 10^DIGITS-1). Go to SHIFT.
//       - If start=0: stay in IDLE.
//     SHIFT (exactly BIN_W cycles):
//       - Step 1: add 3 to every scratch digit that is >= 5.
//       - Step 2: shift {scratch, binreg} left by 1 and decrement count.
//       - When count reaches 1, the next state is DONE.
//     DONE (1 cycle):
//       - bcd <= scratch, overflow <= ovf_next, done=1.
//       - Next state is IDLE.
//   Latency: start accepted on edge N -> done=1 during the cycle after edge N+BIN_W+1.
//     - For the defaults, done appears 9 cycles after start is sampled.
//   bcd/overflow change only on the DONE edge. Intermediate scratch values are never visible.
//   start while busy (SHIFT or DONE) is ignored: no queueing, no restart.
//     - The earliest new start is accepted in the first IDLE cycle after done.
//   bin changes after capture have no effect on the running conversion.
//   Width/overflow rules:
//     - The carry out of the top digit is discarded, so bcd = bin mod 10^DIGITS.
//     - When BIN_W <= floor(log2(10^DIGITS)), overflow is constant 0.
//   Every output digit is in 0..9 for all inputs, so the downstream display never decodes a blank.
// TESTING
//   1 Defaults: reset, bin=8'd255, start pulse -> done after 9 cycles, bcd=12'h255, overflow=0.
//   2 bin=0 -> bcd=12'h000; bin=8'd99 -> bcd=12'h099; bin=8'd100 -> 12'h100; busy high throughout.
//   3 While busy, toggle start and change bin to 8'd7 -> no effect; the first result equals the captured value.
//     A new start in the IDLE cycle after done is then accepted.
//   4 Assert rst at cycle 4 of a conversion -> all outputs 0 immediately, no done pulse.
//     A fresh conversion of 8'd128 then gives 12'h128.
//   5 BIN_W=10, DIGITS=3, bin=10'd1023 -> bcd=12'h023, overflow=1.
//     Then bin=10'd999 -> bcd=12'h999, overflow=0.
//   6 Exhaustive sweep of all 256 inputs with defaults.
//     Compare bcd against a reference divide/mod model, and check done is exactly one cycle wide.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
// One input bit per clock; bcd/overflow update only on the DONE edge and hold between conversions.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic logic [63:0] max_bcd_value(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < d; k++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] BCD_MAX = max_bcd_value(DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [BIN_W-1:0]   binreg_q, binreg_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic               ovf_next_q, ovf_next_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [BCD_W-1:0]   adj;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      binreg_d   = binreg_q;
      scratch_d  = scratch_q;
      ovf_next_d = ovf_next_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      adj = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               binreg_d   = bin;
               scratch_d  = '0;
               count_d    = CNT_W'(BIN_W);
               ovf_next_d = (64'(bin) > BCD_MAX);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // The carry out of the top digit falls off here, giving bin mod 10^DIGITS.
            scratch_d = {adj[BCD_W-2:0], binreg_q[BIN_W-1]};
            binreg_d  = binreg_q << 1;
            count_d   = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d      = scratch_q;
            overflow_d = ovf_next_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         binreg_q   <= '0;
         scratch_q  <= '0;
         ovf_next_q <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         binreg_q   <= binreg_d;
         scratch_q  <= scratch_d;
         ovf_next_q <= ovf_next_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = overflow_q;

endmodule
